// File: rtl/cci_sched_pkg.sv
// Shared types and constants for the CCI page scheduler and its wait timer.
package cci_sched_pkg;

  localparam int DELTA_W         = 16;
  localparam int VOLT_W          = 32;
  localparam int DEFAULT_TIMEOUT = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LEFT,
    S_RD_CENTER,
    S_RD_RIGHT,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_WRITE
  } state_t;

endpackage

// File: rtl/cci_wait_timer.sv
// Loadable down-counter bounding how long the scheduler waits for the
// datapath. Loaded with TIMEOUT-1 when the operation is issued; expire is
// raised during the TIMEOUT-th enabled cycle after the load.
module cci_wait_timer
  import cci_sched_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  // Load wins over clear; count saturates at zero while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= LOAD_VAL;
    end else if (clear) begin
      count_reg <= '0;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expire = en && (count_reg == '0);

endmodule

// File: rtl/cci_page_scheduler.sv
// Walks one wordline cell by cell: gathers the victim word and the i-1/i/i+1
// neighbour deltas, hands them to the CCI datapath, and writes the distorted
// word back. Edge cells get a zero delta for the missing neighbour.
module cci_page_scheduler
  import cci_sched_pkg::*;
#(
  parameter int NUM_CELLS = 32,
  parameter int ADDR_W    = 5,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               page_done,
  output logic               timeout_err,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [VOLT_W-1:0]  victim_rdata,
  input  logic [DELTA_W-1:0] delta_rdata,
  output logic               cci_en,
  output logic [VOLT_W-1:0]  affected_v,
  output logic [DELTA_W-1:0] xy_left,
  output logic [DELTA_W-1:0] y_cci,
  output logic [DELTA_W-1:0] xy_right,
  input  logic [VOLT_W-1:0]  cci_result,
  input  logic               cci_done,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [VOLT_W-1:0]  wr_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CELLS - 1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   idx_reg;
  logic [DELTA_W-1:0]  left_reg, center_reg, right_reg;
  logic [VOLT_W-1:0]   victim_reg, result_reg;
  logic                timeout_err_reg, page_done_reg;

  logic idx_first, idx_last;
  logic accept, finish, abort;
  logic timer_clear, timer_load, timer_en, timer_expire;

  assign idx_first = (idx_reg == '0);
  assign idx_last  = (idx_reg == LAST_IDX);

  cci_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .load   (timer_load),
    .en     (timer_en),
    .expire (timer_expire)
  );

  // Next-state logic plus the strobes that are decoded straight from state.
  always_comb begin
    state_next  = state_reg;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    cci_en      = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    timer_clear = 1'b0;
    timer_load  = 1'b0;
    timer_en    = 1'b0;
    accept      = 1'b0;
    finish      = 1'b0;
    abort       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        timer_clear = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = S_RD_LEFT;
        end
      end
      S_RD_LEFT: begin
        if (!idx_first) begin
          mem_rd   = 1'b1;
          mem_addr = idx_reg - 1'b1;
        end
        state_next = S_RD_CENTER;
      end
      S_RD_CENTER: begin
        mem_rd     = 1'b1;
        mem_addr   = idx_reg;
        state_next = S_RD_RIGHT;
      end
      S_RD_RIGHT: begin
        if (!idx_last) begin
          mem_rd   = 1'b1;
          mem_addr = idx_reg + 1'b1;
        end
        state_next = S_LATCH;
      end
      S_LATCH: begin
        state_next = S_ISSUE;
      end
      S_ISSUE: begin
        cci_en     = 1'b1;
        timer_load = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        timer_en = 1'b1;
        // A done arriving on the final allowed cycle still counts as success.
        if (cci_done) begin
          state_next = S_WRITE;
        end else if (timer_expire) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = idx_reg;
        wr_data = result_reg;
        if (idx_last) begin
          finish     = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_RD_LEFT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, cell index and sticky/pulse status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      idx_reg         <= '0;
      timeout_err_reg <= 1'b0;
      page_done_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      page_done_reg <= finish || abort;
      if (accept) begin
        idx_reg         <= '0;
        timeout_err_reg <= 1'b0;
      end else begin
        if ((state_reg == S_WRITE) && !idx_last) begin
          idx_reg <= idx_reg + 1'b1;
        end
        if (abort) begin
          timeout_err_reg <= 1'b1;
        end
      end
    end
  end

  // Operand capture one cycle after each read; held untouched through WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_reg   <= '0;
      center_reg <= '0;
      right_reg  <= '0;
      victim_reg <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        S_RD_CENTER: left_reg  <= idx_first ? '0 : delta_rdata;
        S_RD_RIGHT: begin
          center_reg <= delta_rdata;
          victim_reg <= victim_rdata;
        end
        S_LATCH:     right_reg <= idx_last ? '0 : delta_rdata;
        S_WAIT:      if (cci_done) result_reg <= cci_result;
        default: ;
      endcase
    end
  end

  assign affected_v  = victim_reg;
  assign xy_left     = left_reg;
  assign y_cci       = center_reg;
  assign xy_right    = right_reg;
  assign timeout_err = timeout_err_reg;
  assign page_done   = page_done_reg;
  // Busy stays up through the page_done cycle and drops right after it.
  assign busy        = (state_reg != S_IDLE) || page_done_reg;

endmodule

// File: doc/cci_page_scheduler.md
# cci_page_scheduler

Sequences cell-to-cell interference (CCI) distortion across one wordline of NUM_CELLS cells. For each victim cell it:
- reads the cell's stored voltage word and the signed neighbour deltas at positions i-1, i and i+1 from the page memories;
- drives the operands into the CCI distortion datapath and waits for its done pulse;
- writes the distorted word back.

It sits between the page buffer (voltage memory plus delta memory, sharing one address) and the single CCI distortion unit in the NVM channel model.

## Interface
Parameters:
- NUM_CELLS, 32, cells per wordline (≥2)
- ADDR_W, 5, cell address width, = clog2(NUM_CELLS)
- TIMEOUT, 15, maximum WAIT cycles before abort (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin page pass; sampled only in IDLE
- busy  out  1  high from the cycle after accepted start until return to IDLE
- page_done  out  1  one-cycle pulse at end of pass (normal or aborted)
- timeout_err  out  1  sticky; set on abort, cleared on next accepted start
- mem_rd  out  1  read strobe, both memories
- mem_addr  out  ADDR_W  read address
- victim_rdata  in  32  voltage word, valid the cycle after mem_rd
- delta_rdata  in  16  signed two's-complement delta, valid the cycle after mem_rd
- cci_en  out  1  one-cycle start pulse to the CCI datapath
- affected_v  out  32  victim voltage word operand
- xy_left, y_cci, xy_right  out  16 each  delta operands for i-1, i, i+1
- cci_result  in  32  distorted word from the datapath
- cci_done  in  1  one-cycle completion pulse
- wr_en  out  1  write strobe, voltage memory
- wr_addr  out  ADDR_W  write address
- wr_data  out  32  write data

## Operation
- States: IDLE, RD_LEFT, RD_CENTER, RD_RIGHT, LATCH, ISSUE, WAIT, WRITE.
- IDLE, start=1: idx←0, timeout_err←0, next state RD_LEFT. A start received outside IDLE is ignored.
- RD_LEFT: mem_rd=1 and mem_addr=idx-1 when idx>0. When idx=0, mem_rd=0 and the left operand is forced to 0.
- RD_CENTER:
  - capture delta_rdata into xy_left (or 0 when idx=0);
  - issue the read of idx.
- RD_RIGHT:
  - capture y_cci←delta_rdata and affected_v←victim_rdata;
  - issue the read of idx+1 when idx<NUM_CELLS-1, else mem_rd=0.
- LATCH: xy_right←delta_rdata, or 0 when idx=NUM_CELLS-1.
- ISSUE: cci_en=1 for exactly one cycle. Then WAIT, with the wait counter cleared.
- WAIT:
  - All operand outputs are held stable.
  - On cci_done: register cci_result and go to WRITE.
  - If TIMEOUT cycles elapse without done: timeout_err←1, pulse page_done, go to IDLE. The current cell is not written.
- WRITE: wr_en=1, wr_addr=idx, wr_data=registered result.
  - If idx=NUM_CELLS-1: pulse page_done, go to IDLE.
  - Otherwise: idx←idx+1, go to RD_LEFT.
- Deltas come from the delta memory, which the scheduler never writes. Write-back of cell i therefore cannot corrupt the operands for cell i+1.
- cci_done seen outside WAIT is ignored.
- Arithmetic: deltas are passed through unmodified. No sign handling or saturation is done here.

## Timing
- Reset value of every output is 0; state=IDLE, idx=0.
- Read latency assumed on the memories: exactly 1 cycle.
- Per-cell cycles: 5 (RD_LEFT..ISSUE) + D (WAIT, D = cycles from cci_en to cci_done, 1≤D≤TIMEOUT) + 1 (WRITE) = 6+D.
- Page latency from accepted start to page_done: NUM_CELLS·(6+D) + 1 cycles.
- page_done asserts in the cycle the FSM leaves WRITE/WAIT. busy falls the following cycle.
- cci_done in the same cycle the wait counter reaches TIMEOUT counts as success: done has priority.
- Reset mid-pass: immediate return to IDLE with all outputs 0. No write is completed and no page_done is issued.

## Structure
- Shared package cci_sched_pkg holds:
  - the state enum;
  - the delta width constant (16) and voltage word width (32);
  - the default TIMEOUT.
- One sub-module, cci_wait_timer: a loadable down-counter with clear and expire output, instantiated for the WAIT timeout.
- The FSM, index counter and operand registers stay in the top module.

## Test plan
- NUM_CELLS=4, datapath model D=4, deltas {+3,-2,+5,+1}, voltages 0x0100_0000 + i → exactly 4 writes at addresses 0..3. Cell 0 gets xy_left=0; cell 3 gets xy_right=0; page_done fires at cycle 4·10+1 after start.
- Negative delta 0xFFFE at idx=1 → appears bit-exact on y_cci for cell 1, xy_left for cell 2 and xy_right for cell 0.
- Datapath never asserts cci_done, TIMEOUT=15 → after 15 WAIT cycles: timeout_err=1, one page_done pulse, no wr_en. The next start clears timeout_err.
- start pulsed while busy, plus a spurious cci_done during RD_CENTER → no restart and no early write. Write count stays NUM_CELLS.
- rst_n asserted during WAIT of cell 2 → all outputs 0 in the same cycle, state IDLE. A subsequent start restarts at idx 0.
- cci_done arrives on exactly the TIMEOUT-th WAIT cycle → write occurs and timeout_err stays 0.
